// File: rtl/alut_aging_engine13.sv
// Address-table aging engine: time base, single-entry age check and
// table-wide invalidation scans (aged / all / by port) over a memory port.
module alut_aging_engine13 #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TIME_W = 32,
  parameter int unsigned MAC_W  = 48,
  parameter int unsigned PORT_W = 2,
  localparam int unsigned DATA_W = 1 + TIME_W + PORT_W + MAC_W
) (
  input  logic              pclk13,
  input  logic              n_p_reset13,
  input  logic [2:0]        command,
  input  logic [7:0]        div_clk13,
  input  logic              check_age13,
  input  logic [TIME_W-1:0] last_accessed13,
  input  logic [TIME_W-1:0] best_bfr_age13,
  input  logic [PORT_W-1:0] inv_port13,
  input  logic              mem_gnt13,
  input  logic [DATA_W-1:0] mem_read_data13,
  output logic [TIME_W-1:0] curr_time13,
  output logic              mem_req13,
  output logic              mem_write13,
  output logic [ADDR_W-1:0] mem_addr13,
  output logic [DATA_W-1:0] mem_write_data13,
  output logic [MAC_W-1:0]  lst_inv_addr13,
  output logic [PORT_W-1:0] lst_inv_port13,
  output logic [ADDR_W:0]   inval_cnt13,
  output logic              age_confirmed13,
  output logic              age_ok13,
  output logic              inval_in_prog13,
  output logic              scan_done13,
  output logic              age_check_active13
);

  localparam logic [2:0] CMD_AGED = 3'b010;
  localparam logic [2:0] CMD_ALL  = 3'b011;
  localparam logic [2:0] CMD_PORT = 3'b100;

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TIME_W-1:0] TIME_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_EVAL, S_WR, S_CHK} state_t;
  typedef enum logic [1:0] {MODE_ALL, MODE_AGED, MODE_PORT} mode_t;

  state_t              state, state_nxt;
  mode_t               mode, mode_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0]   entry, entry_nxt;
  logic [7:0]          div_cnt;

  logic [ADDR_W:0]     inval_cnt_nxt;
  logic [MAC_W-1:0]    lst_addr_nxt;
  logic [PORT_W-1:0]   lst_port_nxt;
  logic                in_prog_nxt, done_nxt, conf_nxt, ok_nxt, active_nxt;
  logic                req_nxt, wr_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                advance;

  logic                entry_valid;
  logic [TIME_W-1:0]   entry_ts;
  logic [PORT_W-1:0]   entry_port;
  logic [MAC_W-1:0]    entry_mac;
  logic [TIME_W-1:0]   entry_elapsed;
  logic [TIME_W-1:0]   chk_elapsed;
  logic                entry_hit;

  assign mem_write_data13 = '0;

  // Field extraction and age arithmetic (modular elapsed time)
  assign entry_valid   = entry[DATA_W-1];
  assign entry_ts      = entry[MAC_W+PORT_W +: TIME_W];
  assign entry_port    = entry[MAC_W +: PORT_W];
  assign entry_mac     = entry[MAC_W-1:0];
  assign entry_elapsed = curr_time13 - entry_ts;
  assign chk_elapsed   = curr_time13 - last_accessed13;
  assign entry_hit     = entry_valid &&
                         (((mode == MODE_AGED) && (entry_elapsed >= best_bfr_age13)) ||
                          ((mode == MODE_PORT) && (entry_port == inv_port13)));

  // Time base: one tick every div_clk13+1 cycles
  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      div_cnt     <= '0;
      curr_time13 <= '0;
    end else if (div_cnt == div_clk13) begin
      div_cnt     <= '0;
      curr_time13 <= curr_time13 + TIME_ONE;
    end else begin
      div_cnt     <= div_cnt + 8'd1;
    end
  end

  // State and registered outputs
  always_ff @(posedge pclk13 or negedge n_p_reset13) begin
    if (!n_p_reset13) begin
      state              <= S_IDLE;
      mode               <= MODE_ALL;
      ptr                <= '0;
      entry              <= '0;
      inval_cnt13        <= '0;
      lst_inv_addr13     <= '0;
      lst_inv_port13     <= '0;
      inval_in_prog13    <= 1'b0;
      scan_done13        <= 1'b0;
      age_confirmed13    <= 1'b0;
      age_ok13           <= 1'b0;
      age_check_active13 <= 1'b0;
      mem_req13          <= 1'b0;
      mem_write13        <= 1'b0;
      mem_addr13         <= '0;
    end else begin
      state              <= state_nxt;
      mode               <= mode_nxt;
      ptr                <= ptr_nxt;
      entry              <= entry_nxt;
      inval_cnt13        <= inval_cnt_nxt;
      lst_inv_addr13     <= lst_addr_nxt;
      lst_inv_port13     <= lst_port_nxt;
      inval_in_prog13    <= in_prog_nxt;
      scan_done13        <= done_nxt;
      age_confirmed13    <= conf_nxt;
      age_ok13           <= ok_nxt;
      age_check_active13 <= active_nxt;
      mem_req13          <= req_nxt;
      mem_write13        <= wr_nxt;
      mem_addr13         <= addr_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode;
    ptr_nxt       = ptr;
    entry_nxt     = entry;
    inval_cnt_nxt = inval_cnt13;
    lst_addr_nxt  = lst_inv_addr13;
    lst_port_nxt  = lst_inv_port13;
    in_prog_nxt   = inval_in_prog13;
    done_nxt      = 1'b0;
    conf_nxt      = 1'b0;
    ok_nxt        = 1'b0;
    req_nxt       = mem_req13;
    wr_nxt        = mem_write13;
    addr_nxt      = mem_addr13;
    advance       = 1'b0;

    case (state)
      S_IDLE: begin
        if ((command == CMD_ALL) || (command == CMD_AGED) || (command == CMD_PORT)) begin
          ptr_nxt       = '0;
          inval_cnt_nxt = '0;
          in_prog_nxt   = 1'b1;
          addr_nxt      = '0;
          req_nxt       = 1'b1;
          if (command == CMD_ALL) begin
            mode_nxt  = MODE_ALL;
            state_nxt = S_WR;
            wr_nxt    = 1'b1;
          end else begin
            mode_nxt  = (command == CMD_AGED) ? MODE_AGED : MODE_PORT;
            state_nxt = S_RD;
            wr_nxt    = 1'b0;
          end
        end else if (check_age13) begin
          state_nxt = S_CHK;
        end
      end
      S_RD: begin
        if (mem_gnt13) begin
          state_nxt = S_RWAIT;
          req_nxt   = 1'b0;
        end
      end
      S_RWAIT: begin
        entry_nxt = mem_read_data13;
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (entry_hit) begin
          state_nxt = S_WR;
          req_nxt   = 1'b1;
          wr_nxt    = 1'b1;
          addr_nxt  = ptr;
        end else begin
          advance = 1'b1;
        end
      end
      S_WR: begin
        if (mem_gnt13) begin
          inval_cnt_nxt = inval_cnt13 + CNT_ONE;
          if (mode != MODE_ALL) begin
            lst_addr_nxt = entry_mac;
            lst_port_nxt = entry_port;
          end
          req_nxt = 1'b0;
          wr_nxt  = 1'b0;
          advance = 1'b1;
        end
      end
      S_CHK: begin
        conf_nxt  = 1'b1;
        ok_nxt    = (chk_elapsed < best_bfr_age13);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Step to the next table entry or finish the scan
    if (advance) begin
      if (ptr == PTR_LAST) begin
        done_nxt    = 1'b1;
        in_prog_nxt = 1'b0;
        state_nxt   = S_IDLE;
        req_nxt     = 1'b0;
        wr_nxt      = 1'b0;
      end else begin
        ptr_nxt  = ptr + PTR_ONE;
        addr_nxt = ptr + PTR_ONE;
        req_nxt  = 1'b1;
        if (mode == MODE_ALL) begin
          state_nxt = S_WR;
          wr_nxt    = 1'b1;
        end else begin
          state_nxt = S_RD;
          wr_nxt    = 1'b0;
        end
      end
    end

    active_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_alut_aging_engine13.sv
// Directed self-checking bench for alut_aging_engine13 with a simple memory model.
module tb_alut_aging_engine13;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TIME_W = 32;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned DATA_W = 1 + TIME_W + PORT_W + MAC_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              pclk13 = 1'b0;
  logic              n_p_reset13;
  logic [2:0]        command;
  logic [7:0]        div_clk13;
  logic              check_age13;
  logic [TIME_W-1:0] last_accessed13;
  logic [TIME_W-1:0] best_bfr_age13;
  logic [PORT_W-1:0] inv_port13;
  logic              mem_gnt13;
  logic [DATA_W-1:0] mem_read_data13;
  logic [TIME_W-1:0] curr_time13;
  logic              mem_req13, mem_write13;
  logic [ADDR_W-1:0] mem_addr13;
  logic [DATA_W-1:0] mem_write_data13;
  logic [MAC_W-1:0]  lst_inv_addr13;
  logic [PORT_W-1:0] lst_inv_port13;
  logic [ADDR_W:0]   inval_cnt13;
  logic              age_confirmed13, age_ok13, inval_in_prog13, scan_done13, age_check_active13;

  // Small-time-width instance used to see the time counter wrap
  logic [3:0]  w_curr_time;
  logic        w_req, w_write, w_conf, w_ok, w_prog, w_done, w_active;
  logic [1:0]  w_addr;
  logic [54:0] w_wdata;
  logic [47:0] w_lst_addr;
  logic [1:0]  w_lst_port;
  logic [2:0]  w_inval_cnt;

  // Bench-side memory model and monitors
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic              tb_clr, ld_en, gnt_tie;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  int                gnt_delay;
  int                wait_cnt, wr_cnt, order_err;
  logic [ADDR_W-1:0] wr_log [4];
  int                done_cnt, viol, stall_cnt;
  logic              waiting, held_wr;
  logic [ADDR_W-1:0] held_addr;

  int n_checks = 0;
  int n_fail   = 0;

  alut_aging_engine13 dut (
    .pclk13(pclk13), .n_p_reset13(n_p_reset13), .command(command), .div_clk13(div_clk13),
    .check_age13(check_age13), .last_accessed13(last_accessed13), .best_bfr_age13(best_bfr_age13),
    .inv_port13(inv_port13), .mem_gnt13(mem_gnt13), .mem_read_data13(mem_read_data13),
    .curr_time13(curr_time13), .mem_req13(mem_req13), .mem_write13(mem_write13),
    .mem_addr13(mem_addr13), .mem_write_data13(mem_write_data13),
    .lst_inv_addr13(lst_inv_addr13), .lst_inv_port13(lst_inv_port13), .inval_cnt13(inval_cnt13),
    .age_confirmed13(age_confirmed13), .age_ok13(age_ok13), .inval_in_prog13(inval_in_prog13),
    .scan_done13(scan_done13), .age_check_active13(age_check_active13)
  );

  alut_aging_engine13 #(.ADDR_W(2), .TIME_W(4)) dut_wrap (
    .pclk13(pclk13), .n_p_reset13(n_p_reset13), .command(3'b000), .div_clk13(8'd0),
    .check_age13(1'b0), .last_accessed13(4'd0), .best_bfr_age13(4'd0),
    .inv_port13(2'd0), .mem_gnt13(1'b0), .mem_read_data13(55'd0),
    .curr_time13(w_curr_time), .mem_req13(w_req), .mem_write13(w_write),
    .mem_addr13(w_addr), .mem_write_data13(w_wdata),
    .lst_inv_addr13(w_lst_addr), .lst_inv_port13(w_lst_port), .inval_cnt13(w_inval_cnt),
    .age_confirmed13(w_conf), .age_ok13(w_ok), .inval_in_prog13(w_prog),
    .scan_done13(w_done), .age_check_active13(w_active)
  );

  always #5 pclk13 = ~pclk13;

  assign mem_gnt13       = gnt_tie | (mem_req13 && (wait_cnt == gnt_delay));
  assign mem_read_data13 = rdata;

  // Memory responder: grant delay, registered read data, write logging
  always @(posedge pclk13) begin
    if (tb_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_cnt    <= 0;
      order_err <= 0;
      wait_cnt  <= 0;
    end else begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (mem_req13 && mem_gnt13) begin
        wait_cnt <= 0;
        if (mem_write13) begin
          mem[mem_addr13] <= mem_write_data13;
          if (wr_cnt < 4) wr_log[wr_cnt] <= mem_addr13;
          if (mem_addr13 != wr_cnt[ADDR_W-1:0]) order_err <= order_err + 1;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rdata <= mem[mem_addr13];
        end
      end else if (mem_req13) begin
        wait_cnt <= wait_cnt + 1;
      end else begin
        wait_cnt <= 0;
      end
    end
  end

  // Monitor: completion pulses, stall cycles and request stability while stalled
  always @(negedge pclk13) begin
    if (tb_clr) begin
      done_cnt  <= 0;
      viol      <= 0;
      stall_cnt <= 0;
      waiting   <= 1'b0;
    end else begin
      if (scan_done13) done_cnt <= done_cnt + 1;
      if (mem_req13 && !mem_gnt13) stall_cnt <= stall_cnt + 1;
      if (waiting && (!mem_req13 || (mem_addr13 != held_addr) || (mem_write13 != held_wr)))
        viol <= viol + 1;
      waiting   <= mem_req13 && !mem_gnt13;
      held_addr <= mem_addr13;
      held_wr   <= mem_write13;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_entry(input logic v, input logic [TIME_W-1:0] ts,
                                                   input logic [PORT_W-1:0] port,
                                                   input logic [MAC_W-1:0] mac);
    return {v, ts, port, mac};
  endfunction

  task automatic do_reset(input logic [7:0] div);
    @(negedge pclk13);
    n_p_reset13 = 1'b0; command = 3'b000; check_age13 = 1'b0; div_clk13 = div;
    gnt_tie = 1'b0; gnt_delay = 0; tb_clr = 1'b1;
    @(negedge pclk13);
    tb_clr = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge pclk13);
    n_p_reset13 = 1'b1;
  endtask

  task automatic clear_tb();
    @(negedge pclk13); tb_clr = 1'b1;
    @(negedge pclk13); tb_clr = 1'b0;
  endtask

  task automatic load(input int a, input logic [DATA_W-1:0] d);
    @(negedge pclk13);
    ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = d;
    @(negedge pclk13);
    ld_en = 1'b0;
  endtask

  task automatic issue_cmd(input logic [2:0] c);
    @(negedge pclk13); command = c;
    @(negedge pclk13); command = 3'b000;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge pclk13);
      n++;
    end
    @(negedge pclk13);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_in_prog_end"}, 64'(inval_in_prog13), 64'd0);
  endtask

  task automatic age_check(input string tag, input logic [TIME_W-1:0] last,
                           input logic [TIME_W-1:0] bba, input logic exp_ok);
    @(negedge pclk13); last_accessed13 = last; best_bfr_age13 = bba; check_age13 = 1'b1;
    @(negedge pclk13); check_age13 = 1'b0;
    check_eq({tag, "_active"}, 64'(age_check_active13), 64'd1);
    @(posedge pclk13); #1;
    check_eq({tag, "_confirmed"}, 64'(age_confirmed13), 64'd1);
    check_eq({tag, "_ok"}, 64'(age_ok13), 64'(exp_ok));
    @(posedge pclk13); #1;
    check_eq({tag, "_confirmed_drop"}, 64'(age_confirmed13), 64'd0);
  endtask

  task automatic wait_time(input logic [TIME_W-1:0] t);
    int n = 0;
    while (curr_time13 != t && n < 400) begin
      @(negedge pclk13);
      n++;
    end
    div_clk13 = 8'd255;
    check_eq("time_reached", 64'(curr_time13), 64'(t));
  endtask

  initial begin
    logic [DATA_W-1:0] e5, e9, e30, p3, p7, p20, p200;
    int n;

    n_p_reset13 = 1'b0; command = '0; div_clk13 = 8'd3; check_age13 = 1'b0;
    last_accessed13 = '0; best_bfr_age13 = '0; inv_port13 = '0;
    gnt_tie = 1'b0; gnt_delay = 0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; tb_clr = 1'b1;

    // Reset state and divider / wrap
    repeat (3) @(posedge pclk13);
    @(negedge pclk13); tb_clr = 1'b0;
    check_eq("rst_mem_req", 64'(mem_req13), 64'd0);
    check_eq("rst_curr_time", 64'(curr_time13), 64'd0);
    check_eq("rst_inval_cnt", 64'(inval_cnt13), 64'd0);
    check_eq("rst_active", 64'(age_check_active13), 64'd0);
    check_eq("rst_lst_addr", 64'(lst_inv_addr13), 64'd0);
    @(negedge pclk13); n_p_reset13 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge pclk13); #1;
      if (c == 4)  check_eq("div_first_tick", 64'(curr_time13), 64'd1);
      if (c == 15) check_eq("wrap_max", 64'(w_curr_time), 64'd15);
      if (c == 16) check_eq("wrap_zero", 64'(w_curr_time), 64'd0);
    end
    check_eq("div_40_cycles", 64'(curr_time13), 64'd10);

    // Single age checks
    do_reset(8'd0);
    release_reset();
    wait_time(32'd100);
    age_check("chk_bba10", 32'd90, 32'd10, 1'b0);
    age_check("chk_bba11", 32'd90, 32'd11, 1'b1);
    do_reset(8'd0);
    release_reset();
    wait_time(32'd5);
    age_check("chk_wrap_bba8", 32'hFFFF_FFFD, 32'd8, 1'b0);
    age_check("chk_wrap_bba9", 32'hFFFF_FFFD, 32'd9, 1'b1);

    // Invalidate aged entries
    e5  = make_entry(1'b1, 32'hFFFF_FF9C, 2'd1, 48'h0000_1111_2222);
    e9  = make_entry(1'b1, 32'h0000_0000, 2'd3, 48'hAAAA_BBBB_CCCC);
    e30 = make_entry(1'b0, 32'hFFFF_FF00, 2'd2, 48'h3030_3030_3030);
    do_reset(8'd255);
    load(5, e5); load(9, e9); load(30, e30);
    release_reset();
    best_bfr_age13 = 32'd50;
    issue_cmd(3'b010);
    check_eq("aged_first_addr", 64'(mem_addr13), 64'd0);
    check_eq("aged_in_prog", 64'(inval_in_prog13), 64'd1);
    wait_done("aged", 3000);
    check_eq("aged_inval_cnt", 64'(inval_cnt13), 64'd1);
    check_eq("aged_writes", 64'(wr_cnt), 64'd1);
    check_eq("aged_write_addr", 64'(wr_log[0]), 64'd5);
    check_eq("aged_lst_addr", 64'(lst_inv_addr13), 64'h0000_1111_2222);
    check_eq("aged_lst_port", 64'(lst_inv_port13), 64'd1);
    check_eq("aged_e5_cleared", 64'(mem[5] == '0), 64'd1);
    check_eq("aged_e9_kept", 64'(mem[9] == e9), 64'd1);
    check_eq("aged_e30_kept", 64'(mem[30] == e30), 64'd1);

    // Invalidate all, grant tied high; last-invalidated fields untouched
    clear_tb();
    gnt_tie = 1'b1;
    issue_cmd(3'b011);
    wait_done("all", 1000);
    check_eq("all_inval_cnt", 64'(inval_cnt13), 64'd256);
    check_eq("all_writes", 64'(wr_cnt), 64'd256);
    check_eq("all_write_order", 64'(order_err), 64'd0);
    check_eq("all_lst_addr", 64'(lst_inv_addr13), 64'h0000_1111_2222);
    check_eq("all_lst_port", 64'(lst_inv_port13), 64'd1);
    gnt_tie = 1'b0;

    // Invalidate by port with a 3-cycle grant delay
    p3   = make_entry(1'b1, 32'd0, 2'd2, 48'h0303_0303_0303);
    p7   = make_entry(1'b1, 32'd0, 2'd1, 48'h0707_0707_0707);
    p20  = make_entry(1'b0, 32'd0, 2'd2, 48'h2020_2020_2020);
    p200 = make_entry(1'b1, 32'd0, 2'd2, 48'hC8C8_C8C8_C8C8);
    do_reset(8'd255);
    gnt_delay = 3;
    load(3, p3); load(7, p7); load(20, p20); load(200, p200);
    inv_port13 = 2'd2;
    release_reset();
    issue_cmd(3'b100);
    wait_done("port", 4000);
    check_eq("port_inval_cnt", 64'(inval_cnt13), 64'd2);
    check_eq("port_writes", 64'(wr_cnt), 64'd2);
    check_eq("port_write0", 64'(wr_log[0]), 64'd3);
    check_eq("port_write1", 64'(wr_log[1]), 64'd200);
    check_eq("port_lst_addr", 64'(lst_inv_addr13), 64'hC8C8_C8C8_C8C8);
    check_eq("port_lst_port", 64'(lst_inv_port13), 64'd2);
    check_eq("port_stable", 64'(viol), 64'd0);
    check_eq("port_stall_cycles", 64'(stall_cnt), 64'd774);
    check_eq("port_e7_kept", 64'(mem[7] == p7), 64'd1);
    check_eq("port_e20_kept", 64'(mem[20] == p20), 64'd1);

    // Reset in the middle of a scan, then restart
    do_reset(8'd255);
    release_reset();
    best_bfr_age13 = 32'd50;
    issue_cmd(3'b010);
    n = 0;
    while (!(mem_req13 && !mem_write13 && mem_addr13 == 8'd17) && n < 200) begin
      @(negedge pclk13);
      n++;
    end
    check_eq("mid_reached_17", 64'(mem_addr13), 64'd17);
    #1 n_p_reset13 = 1'b0;
    #1;
    check_eq("mid_rst_req", 64'(mem_req13), 64'd0);
    check_eq("mid_rst_addr", 64'(mem_addr13), 64'd0);
    check_eq("mid_rst_in_prog", 64'(inval_in_prog13), 64'd0);
    check_eq("mid_rst_active", 64'(age_check_active13), 64'd0);
    check_eq("mid_rst_time", 64'(curr_time13), 64'd0);
    repeat (3) @(negedge pclk13);
    check_eq("mid_no_done", 64'(done_cnt), 64'd0);
    n_p_reset13 = 1'b1;
    issue_cmd(3'b010);
    check_eq("restart_req", 64'(mem_req13), 64'd1);
    check_eq("restart_addr", 64'(mem_addr13), 64'd0);
    check_eq("restart_is_read", 64'(mem_write13), 64'd0);
    wait_done("restart", 3000);
    check_eq("restart_inval_cnt", 64'(inval_cnt13), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
